// File: rtl/approx_mul_err_monitor.sv
// Error-statistics monitor for unsigned approximate multipliers: accepts (x, y, z) triples,
// recomputes x*y exactly and accumulates error count, summed and maximum error distance.
module approx_mul_err_monitor #(
    parameter int WIDTH     = 8,
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17,
    parameter int SUM_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     max_x,
    output logic [WIDTH-1:0]     max_y
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic             accept, last_accept, clear_stats;
    logic             v1, v2;
    logic [WIDTH-1:0] x1, y1, x2, y2;
    logic [PW-1:0]    z1, exact, ed, ed2;
    logic [SUM_W:0]   sum_wide;
    logic [SUM_W-1:0] sum_next;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign clear_stats = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (last_accept) state_next = DRAIN;
            DRAIN:      if (!v1 && !v2) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            x1         <= '0;
            y1         <= '0;
            z1         <= '0;
            sample_cnt <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                x1 <= x;
                y1 <= y;
                z1 <= z;
            end
            if (clear_stats) begin
                sample_cnt <= '0;
            end else if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    // Error distance is an unsigned magnitude, so z may sit on either side of the exact product.
    assign exact = PW'(x1) * PW'(y1);
    assign ed    = (exact >= z1) ? (exact - z1) : (z1 - exact);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            ed2 <= '0;
            x2  <= '0;
            y2  <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                ed2 <= ed;
                x2  <= x1;
                y2  <= y1;
            end
        end
    end

    assign sum_wide = {1'b0, sum_ed} + (SUM_W + 1)'(ed2);
    assign sum_next = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

    // Strict greater-than keeps the earliest triple when several share the maximum.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
            max_x   <= '0;
            max_y   <= '0;
        end else if (v2) begin
            sum_ed  <= sum_next;
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, (ed2 != '0)};
            if (ed2 > max_ed) begin
                max_ed <= ed2;
                max_x  <= x2;
                max_y  <= y2;
            end
        end
    end
endmodule
